// File: rtl/breakout_pkg.sv
// Shared types and constants for the Breakout game-flow sequencer.
// screen_of maps a sequencer state to the VGA source it displays.
package breakout_pkg;

  typedef enum logic [2:0] {
    S_MENU,
    S_ARM,
    S_PLAY,
    S_OVER,
    S_WIN
  } seq_state_t;

  localparam logic [1:0] SCR_MENU = 2'd0;
  localparam logic [1:0] SCR_GAME = 2'd1;
  localparam logic [1:0] SCR_OVER = 2'd2;
  localparam logic [1:0] SCR_WIN  = 2'd3;

  localparam int DEFAULT_SCORE_W = 9;

  function automatic logic [1:0] screen_of(input seq_state_t s);
    case (s)
      S_PLAY:  return SCR_GAME;
      S_OVER:  return SCR_OVER;
      S_WIN:   return SCR_WIN;
      default: return SCR_MENU;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: a level is accepted after DEBOUNCE_CYCLES equal samples;
// press pulses for one cycle when the accepted level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      btn_q <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      btn_q <= btn;
      press <= 1'b0;
      if (btn != btn_q) begin
        cnt <= RELOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else if (level != btn_q) begin
        level <= btn_q;
        press <= btn_q;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Breakout game-flow controller: debounced start button, menu/play/end phases,
// high-score tracking and frame-aligned VGA source switching.
//
//   state  | meaning
//   S_MENU | title screen, waiting for a press
//   S_ARM  | game core reset issued, waiting for a frame boundary to start
//   S_PLAY | game core running, live score shown
//   S_OVER | ball lost, digits blanked, hold until press or timeout
//   S_WIN  | all bricks cleared, hold until press or timeout
module game_sequencer
  import breakout_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_FRAMES     = 600,
  parameter int SCORE_W         = DEFAULT_SCORE_W
) (
  input  logic               CLK,
  input  logic               RST_BTN,
  input  logic               BTNC,
  input  logic               vga_vs,
  input  logic               endgame,
  input  logic               win_game,
  input  logic [SCORE_W-1:0] curr_score,
  output logic [1:0]         screen_sel,
  output logic               game_en,
  output logic               game_rst,
  output logic [SCORE_W-1:0] high_score,
  output logic               score_sel,
  output logic               an_blank
);

  localparam int FCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [FCW-1:0] HOLD_LAST = FCW'(HOLD_FRAMES - 1);

  seq_state_t     state, state_nxt;
  logic           btn_level, btn_press, press;
  logic           vs_q, frame, hold_done, game_end, to_menu, holding;
  logic [FCW-1:0] hold_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_sys(CLK),
    .rst_b  (RST_BTN),
    .btn    (BTNC),
    .level  (btn_level),
    .press  (btn_press)
  );

  // press and level rise on the same edge; the gate ties the event to the accepted level
  assign press     = btn_press & btn_level;
  assign frame     = vs_q & ~vga_vs;
  assign holding   = (state == S_OVER) || (state == S_WIN);
  assign hold_done = frame && (hold_cnt == HOLD_LAST);
  assign game_end  = (state == S_PLAY) && ((state_nxt == S_OVER) || (state_nxt == S_WIN));
  assign to_menu   = (state != S_MENU) && (state_nxt == S_MENU);

  always_comb begin
    state_nxt = state;
    case (state)
      S_MENU: if (press) state_nxt = S_ARM;
      S_ARM:  if (frame) state_nxt = S_PLAY;
      S_PLAY: begin
        if (win_game)     state_nxt = S_WIN;
        else if (endgame) state_nxt = S_OVER;
      end
      S_OVER, S_WIN: if (press || hold_done) state_nxt = S_MENU;
      default: state_nxt = S_MENU;
    endcase
  end

  assign game_en   = (state == S_PLAY);
  assign score_sel = (state == S_PLAY) || holding;
  assign an_blank  = (state == S_OVER);

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state    <= S_MENU;
      vs_q     <= 1'b1;
      game_rst <= 1'b0;
    end else begin
      state    <= state_nxt;
      vs_q     <= vga_vs;
      game_rst <= (state == S_MENU) && press;
    end
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      hold_cnt   <= '0;
      high_score <= '0;
    end else if (game_end) begin
      hold_cnt <= '0;
      if (curr_score > high_score) high_score <= curr_score;
    end else if (holding && frame && (hold_cnt != HOLD_LAST)) begin
      hold_cnt <= hold_cnt + FCW'(1);
    end
  end

  // the source only moves on a frame edge, except the jump back to the menu
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      screen_sel <= SCR_MENU;
    end else if (to_menu) begin
      screen_sel <= SCR_MENU;
    end else if (frame) begin
      screen_sel <= screen_of(state_nxt);
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scenario bench for game_sequencer with a score-level reference model
// (high score is the running maximum of finished games).
module tb_game_sequencer;

  localparam int DEB  = 16;
  localparam int HOLD = 4;
  localparam int SW   = 9;

  logic          CLK = 1'b0;
  logic          RST_BTN = 1'b0;
  logic          BTNC = 1'b0;
  logic          vga_vs = 1'b1;
  logic          endgame = 1'b0;
  logic          win_game = 1'b0;
  logic [SW-1:0] curr_score = '0;
  logic [1:0]    screen_sel;
  logic          game_en, game_rst, score_sel, an_blank;
  logic [SW-1:0] high_score;

  int vectors = 0;
  int miscompares = 0;
  int mdl_high = 0;

  game_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_FRAMES    (HOLD),
    .SCORE_W        (SW)
  ) dut (
    .CLK       (CLK),
    .RST_BTN   (RST_BTN),
    .BTNC      (BTNC),
    .vga_vs    (vga_vs),
    .endgame   (endgame),
    .win_game  (win_game),
    .curr_score(curr_score),
    .screen_sel(screen_sel),
    .game_en   (game_en),
    .game_rst  (game_rst),
    .high_score(high_score),
    .score_sel (score_sel),
    .an_blank  (an_blank)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic frame_pulse();
    vga_vs = 1'b0;
    tick(1);
    vga_vs = 1'b1;
    tick(1);
  endtask

  // press accepted DEB+1 edges after the change; state moves one edge later
  task automatic press_btn();
    BTNC = 1'b1;
    tick(DEB + 2);
    BTNC = 1'b0;
    tick(DEB + 2);
  endtask

  task automatic start_game();
    press_btn();
    frame_pulse();
  endtask

  task automatic end_game(input int score, input logic lose, input logic win);
    curr_score = SW'(score);
    endgame = lose;
    win_game = win;
    tick(1);
    endgame = 1'b0;
    win_game = 1'b0;
    if (score > mdl_high) mdl_high = score;
  endtask

  task automatic apply_reset();
    RST_BTN = 1'b0;
    tick(2);
    RST_BTN = 1'b1;
    tick(2);
    mdl_high = 0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({screen_sel, game_en, game_rst, score_sel, an_blank} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000000",
               {screen_sel, game_en, game_rst, score_sel, an_blank});
    end
    vectors++;
    if (high_score !== '0) begin
      miscompares++;
      $display("FAIL reset_high_score: got %0d want 0", high_score);
    end
    RST_BTN = 1'b1;
    tick(2);
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int at = -1;
    for (int i = 0; i < 12; i++) begin
      BTNC = ~BTNC;
      for (int c = 0; c < 5; c++) begin
        tick(1);
        if (game_rst) pulses++;
      end
    end
    BTNC = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick(1);
      if (game_rst) begin
        pulses++;
        if (at < 0) at = j;
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL bounce_press_count: got %0d want 1", pulses);
    end
    // game_rst trails the press pulse by one cycle
    vectors++;
    if (at != DEB + 2) begin
      miscompares++;
      $display("FAIL bounce_latency: got %0d want %0d", at - 1, DEB + 1);
    end
    BTNC = 1'b0;
    tick(DEB + 2);
  endtask

  task automatic test_start();
    vectors++;
    if (game_en !== 1'b0 || screen_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL arm_idle: got en=%b scr=%0d want en=0 scr=0", game_en, screen_sel);
    end
    vga_vs = 1'b0;
    tick(1);
    vectors++;
    if (game_en !== 1'b1 || screen_sel !== 2'd1 || score_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL start_play: got en=%b scr=%0d ssel=%b want en=1 scr=1 ssel=1",
               game_en, screen_sel, score_sel);
    end
    vga_vs = 1'b1;
    tick(1);
  endtask

  task automatic test_lose_record();
    end_game(20, 1'b1, 1'b0);
    vectors++;
    if (high_score !== SW'(20) || game_en !== 1'b0) begin
      miscompares++;
      $display("FAIL first_loss: got hs=%0d en=%b want hs=20 en=0", high_score, game_en);
    end
    press_btn();
    start_game();
    end_game(37, 1'b1, 1'b0);
    vectors++;
    if (game_en !== 1'b0 || high_score !== SW'(37)) begin
      miscompares++;
      $display("FAIL loss_record: got en=%b hs=%0d want en=0 hs=37", game_en, high_score);
    end
    vectors++;
    if (screen_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL screen_waits_frame: got %0d want 1", screen_sel);
    end
    frame_pulse();
    vectors++;
    if (screen_sel !== 2'd2 || an_blank !== 1'b1) begin
      miscompares++;
      $display("FAIL over_screen: got scr=%0d blank=%b want scr=2 blank=1", screen_sel, an_blank);
    end
    for (int f = 1; f < HOLD - 1; f++) frame_pulse();
    vectors++;
    if (screen_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL over_hold: got %0d want 2", screen_sel);
    end
    frame_pulse();
    vectors++;
    if (screen_sel !== 2'd0 || an_blank !== 1'b0 || score_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL over_timeout: got scr=%0d blank=%b ssel=%b want 0 0 0",
               screen_sel, an_blank, score_sel);
    end
  endtask

  task automatic test_press_in_play();
    start_game();
    press_btn();
    vectors++;
    if (game_en !== 1'b1 || screen_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL press_in_play: got en=%b scr=%0d want en=1 scr=1", game_en, screen_sel);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    start_game();
    end_game(9, 1'b1, 1'b0);
    press_btn();
    start_game();
    end_game(5, 1'b1, 1'b1);
    vectors++;
    if (an_blank !== 1'b0 || game_en !== 1'b0 || high_score !== SW'(mdl_high)) begin
      miscompares++;
      $display("FAIL both_events: got blank=%b en=%b hs=%0d want 0 0 %0d",
               an_blank, game_en, high_score, mdl_high);
    end
    frame_pulse();
    vectors++;
    if (screen_sel !== 2'd3) begin
      miscompares++;
      $display("FAIL win_screen: got %0d want 3", screen_sel);
    end
  endtask

  task automatic test_press_timeout();
    int rst_seen = 0;
    for (int f = 1; f < HOLD - 1; f++) frame_pulse();
    vectors++;
    if (screen_sel !== 2'd3) begin
      miscompares++;
      $display("FAIL win_hold: got %0d want 3", screen_sel);
    end
    BTNC = 1'b1;
    tick(DEB + 1);
    vga_vs = 1'b0;
    tick(1);
    vectors++;
    if (screen_sel !== 2'd0 || score_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL press_at_timeout: got scr=%0d ssel=%b want 0 0", screen_sel, score_sel);
    end
    vga_vs = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      if (game_rst) rst_seen++;
    end
    vectors++;
    if (rst_seen != 0) begin
      miscompares++;
      $display("FAIL single_transition: got %0d game_rst pulses want 0", rst_seen);
    end
    BTNC = 1'b0;
    tick(DEB + 2);
  endtask

  task automatic test_async_reset();
    int rst_seen = 0;
    start_game();
    #3;
    RST_BTN = 1'b0;
    #1;
    vectors++;
    if ({screen_sel, game_en, game_rst, score_sel, an_blank} !== 6'b0 || high_score !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got out=%b hs=%0d want 000000 hs=0",
               {screen_sel, game_en, game_rst, score_sel, an_blank}, high_score);
    end
    tick(1);
    RST_BTN = 1'b1;
    mdl_high = 0;
    tick(2);
    for (int f = 0; f < 3; f++) frame_pulse();
    vectors++;
    if (game_en !== 1'b0 || screen_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got en=%b scr=%0d want 0 0", game_en, screen_sel);
    end
    BTNC = 1'b1;
    for (int c = 0; c < DEB + 4; c++) begin
      tick(1);
      if (game_rst) rst_seen++;
    end
    vectors++;
    if (rst_seen != 1) begin
      miscompares++;
      $display("FAIL restart_press: got %0d game_rst pulses want 1", rst_seen);
    end
    BTNC = 1'b0;
    tick(DEB + 2);
    frame_pulse();
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 10; g++) begin
      int score = int'($urandom_range(0, 511));
      int kind = int'($urandom_range(0, 2));
      logic lose = (kind != 1);
      logic win = (kind != 0);
      logic [1:0] exp_scr = win ? 2'd3 : 2'd2;
      if (g != 0) start_game();
      for (int f = 0; f < int'($urandom_range(0, 2)); f++) frame_pulse();
      tick(int'($urandom_range(1, 6)));
      vectors++;
      if (game_en !== 1'b1 || screen_sel !== 2'd1) begin
        miscompares++;
        $display("FAIL rnd_play g%0d: got en=%b scr=%0d want 1 1", g, game_en, screen_sel);
      end
      end_game(score, lose, win);
      vectors++;
      if (game_en !== 1'b0 || high_score !== SW'(mdl_high) || an_blank !== (lose & ~win)) begin
        miscompares++;
        $display("FAIL rnd_end g%0d: got en=%b hs=%0d blank=%b want 0 %0d %b",
                 g, game_en, high_score, an_blank, mdl_high, lose & ~win);
      end
      frame_pulse();
      vectors++;
      if (screen_sel !== exp_scr) begin
        miscompares++;
        $display("FAIL rnd_screen g%0d: got %0d want %0d", g, screen_sel, exp_scr);
      end
      if ($urandom_range(0, 1) == 1) press_btn();
      else for (int f = 1; f < HOLD; f++) frame_pulse();
      vectors++;
      if (screen_sel !== 2'd0 || score_sel !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_exit g%0d: got scr=%0d ssel=%b want 0 0", g, screen_sel, score_sel);
      end
    end
  endtask

  initial begin
    tick(2);
    test_reset();
    test_bounce();
    test_start();
    test_lose_record();
    test_press_in_play();
    test_simultaneous();
    test_press_timeout();
    test_async_reset();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Registered game-flow controller for the Breakout top level. It replaces the free-running mode toggle and the purely combinational screen multiplexing with a state machine that debounces BTNC, sequences menu, play, game-over and win phases, and issues a one-cycle reset to the game core on every new game. It keeps the high score and switches the VGA source only at frame boundaries, so the display never tears mid-frame.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: stable cycles required before a BTNC level is accepted (10 ms at 100 MHz).
- HOLD_FRAMES, 600: frames that OVER or WIN persists before returning to MENU without a press.
- SCORE_W, 9: score width.

Ports:
- CLK  in  1  100 MHz system clock; the only clock.
- RST_BTN  in  1  asynchronous, active-low reset.
- BTNC  in  1  raw mode button, already synchronous to CLK.
- vga_vs  in  1  vertical sync of the currently selected source, active-low pulse.
- endgame  in  1  level from game core; ball lost.
- win_game  in  1  level from game core; all bricks cleared.
- curr_score  in  SCORE_W  live score from game core.
- screen_sel  out  2  VGA source select: 0 menu, 1 game, 2 over, 3 win.
- game_en  out  1  game core runs while high.
- game_rst  out  1  one-cycle reset pulse to game core and score.
- high_score  out  SCORE_W  best score since reset.
- score_sel  out  1  7-seg source: 0 high_score, 1 curr_score.
- an_blank  out  1  forces all anodes off when high.

## Operation
- Debounce: counter reloads on every BTNC change; the debounced level updates after DEBOUNCE_CYCLES equal samples. `press` is a one-cycle pulse on the debounced rising edge. Releases never generate an event.
- Frame boundary: `frame` is a one-cycle pulse on the falling edge of vga_vs, detected with one register stage.
- States (breakout_pkg::seq_state_t): S_MENU, S_ARM, S_PLAY, S_OVER, S_WIN.
- S_MENU:
  - Outputs: game_en=0, score_sel=0, an_blank=0.
  - On press, go to S_ARM and pulse game_rst in the same transition cycle.
- S_ARM:
  - Holds game_en=0.
  - On frame, go to S_PLAY.
  - A press in S_ARM is ignored.
- S_PLAY:
  - Outputs: game_en=1, score_sel=1.
  - If win_game, go to S_WIN; otherwise if endgame, go to S_OVER. If both are high in the same cycle, S_WIN wins.
  - A press in S_PLAY is ignored.
- Entry to S_OVER or S_WIN:
  - game_en=0.
  - high_score ← max(high_score, curr_score), unsigned compare, sampled on the transition cycle.
  - The frame counter clears.
- S_OVER and S_WIN:
  - score_sel=1. an_blank=1 in S_OVER only.
  - The frame counter increments on each frame.
  - A press, or the counter reaching HOLD_FRAMES-1 together with a frame, returns to S_MENU. Press takes priority; both events in the same cycle produce one transition.
- screen_sel:
  - Its target is the state's screen (MENU/ARM→0, PLAY→1, OVER→2, WIN→3).
  - The output register loads the target only on a frame pulse. Exception: any transition into S_MENU loads 0 immediately.

## Timing
- Reset values: state S_MENU, screen_sel 0, game_en 0, game_rst 0, high_score 0, score_sel 0, an_blank 0, debounce counter 0, debounced level 0, frame counter 0.
- Reset mid-game returns to S_MENU within the same cycle (asynchronous) and clears high_score.
- Press latency: from the BTNC edge to the `press` pulse is DEBOUNCE_CYCLES+1 cycles.
- game_rst is high exactly one cycle, the cycle the state register enters S_ARM.
- game_en rises the cycle after the frame pulse that moves S_ARM→S_PLAY.
- endgame or win_game to game_en low: 1 cycle.
- screen_sel changes at most once per frame, except when forced to 0.
- Width: the frame counter is clog2(HOLD_FRAMES) bits and never wraps, because it stops at the terminal count.

## Structure
- breakout_pkg holds:
  - seq_state_t;
  - screen codes SCR_MENU/SCR_GAME/SCR_OVER/SCR_WIN;
  - default SCORE_W.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES) produces the debounced level and the press pulse, and is reusable for other buttons.
- The FSM, frame-edge detector, hold counter and high-score register live in game_sequencer. The top-level output mux becomes a case on screen_sel, score_sel and an_blank.

## Test plan
- Bounce: DEBOUNCE_CYCLES=16; BTNC toggles every 5 cycles for 60 cycles, then holds high. Expect exactly one press, 17 cycles after the last edge.
- Start: press in S_MENU. Expect game_rst high for 1 cycle and game_en still 0. On the next vga_vs fall, expect game_en=1 and screen_sel=1 one cycle later.
- Lose with record: curr_score=37, high_score=20, endgame asserted. Expect game_en=0 next cycle and high_score=37. screen_sel=2 and an_blank=1 at the next frame; return to MENU after HOLD_FRAMES=4 frames.
- Simultaneous events: endgame and win_game asserted in the same cycle with curr_score=5 and high_score=9. Expect S_WIN, screen_sel=3 and high_score stays 9.
- Press during play and press at timeout: a press in S_PLAY causes no change. A press in S_WIN on the same cycle as the terminal frame gives a single move to S_MENU with screen_sel=0 that cycle.
- Async reset: assert RST_BTN=0 mid-S_PLAY between clock edges. Expect all outputs at reset values immediately; after release, a press is needed to start again.
